// File: rtl/sargantana_itag_memory_param.sv
// sargantana_itag_memory_param
// Parametrised I-cache tag store: N_WAY ways x DEPTH sets of TAG_W-bit tags.
// Tags live in a single-port behavioural array and valid bits in flops.
// The tag compare happens in the read stage, and the per-way hit vector is
// registered, so it appears one cycle after the lookup.
// After reset, a hardware sweep writes zero to every tag row before any
// request is accepted.
// Optional feature: define ITAG_PARITY_EN to store an even-parity bit per
// way. A read whose parity check fails reports parity_err_o and is treated
// as a miss.
//
// Handshake: ready_o high means a request on req_i is taken in that cycle.
// The read results (tag_way_o, vbit_o, hit_way_o, hit_o, parity_err_o) are
// qualified by a one-cycle rvalid_o pulse on the following cycle.
module sargantana_itag_memory_param #(
    parameter int  N_WAY = 4,
    parameter int  DEPTH = 64,
    parameter int  TAG_W = 20,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_WAY-1:0]         req_i,
    input  logic                     we_i,
    input  logic                     vbit_i,
    input  logic                     flush_i,
    input  logic [TAG_W-1:0]         data_i,
    input  logic [IDX_W-1:0]         addr_i,
    input  logic [TAG_W-1:0]         cmp_tag_i,
    output logic                     ready_o,
    output logic                     rvalid_o,
    output logic [N_WAY*TAG_W-1:0]   tag_way_o,
    output logic [N_WAY-1:0]         vbit_o,
    output logic [N_WAY-1:0]         hit_way_o,
    output logic                     hit_o,
    output logic [N_WAY-1:0]         parity_err_o
);

    // Elaboration-time parameter sanity checks
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if ((N_WAY < 1) || (N_WAY > 8)) begin : g_bad_nway
        $error("N_WAY must be in 1..8");
    end

`ifdef ITAG_PARITY_EN
    localparam int MEM_W = TAG_W + 1;
`else
    localparam int MEM_W = TAG_W;
`endif

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    logic [MEM_W-1:0]  mem [N_WAY][DEPTH];
    logic [N_WAY-1:0]  valid_q [DEPTH];

    logic              rd_go, wr_go, fl_go;
    logic [N_WAY-1:0]  mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [MEM_W-1:0]  mem_wdata;

    logic [TAG_W-1:0]  rd_tag [N_WAY];
    logic [N_WAY-1:0]  rd_perr;
    logic [N_WAY-1:0]  rd_valid;

    // Sweep state and row counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance through rows, finish after the last one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = S_READY;
            end
        end
    end

    assign ready_o = (state_q == S_READY);
    // Flush wins over any concurrent request
    assign fl_go   = ready_o & flush_i;
    assign rd_go   = ready_o & ~flush_i & (|req_i) & ~we_i;
    assign wr_go   = ready_o & ~flush_i & (|req_i) & we_i;

    // Single write port shared by the init sweep and normal writes
    always_comb begin
        mem_we    = '0;
        mem_addr  = addr_i;
`ifdef ITAG_PARITY_EN
        mem_wdata = {^data_i, data_i};
`else
        mem_wdata = data_i;
`endif
        if (state_q == S_INIT) begin
            mem_we    = '1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
        end else if (wr_go) begin
            mem_we    = req_i;
        end
    end

    // Tag array write (behavioural single-port RAM, no reset)
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < N_WAY; w++) begin
            if (mem_we[w]) begin
                mem[w][mem_addr] <= mem_wdata;
            end
        end
    end

    // Valid bits: cleared by reset or flush, updated by writes to requested ways
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < DEPTH; s++) begin
                valid_q[s] <= '0;
            end
        end else if (fl_go) begin
            for (int s = 0; s < DEPTH; s++) begin
                valid_q[s] <= '0;
            end
        end else if (wr_go) begin
            valid_q[addr_i] <= (valid_q[addr_i] & ~req_i) | (req_i & {N_WAY{vbit_i}});
        end
    end

    // Read-side tag fetch, parity check and qualified valid per way
    always_comb begin
        for (int w = 0; w < N_WAY; w++) begin
            rd_tag[w] = mem[w][addr_i][TAG_W-1:0];
`ifdef ITAG_PARITY_EN
            rd_perr[w] = ^mem[w][addr_i];
`else
            rd_perr[w] = 1'b0;
`endif
            rd_valid[w] = valid_q[addr_i][w] & ~rd_perr[w];
        end
    end

    // Registered read results; the hit vector is computed from the live compare
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o  <= 1'b0;
            tag_way_o <= '0;
            vbit_o    <= '0;
            hit_way_o <= '0;
        end else begin
            rvalid_o <= rd_go;
            if (fl_go) begin
                vbit_o    <= '0;
                hit_way_o <= '0;
            end else if (rd_go) begin
                for (int w = 0; w < N_WAY; w++) begin
                    if (req_i[w]) begin
                        tag_way_o[w*TAG_W +: TAG_W] <= rd_tag[w];
                    end
                    vbit_o[w]    <= req_i[w] & rd_valid[w];
                    hit_way_o[w] <= req_i[w] & rd_valid[w] & (rd_tag[w] == cmp_tag_i);
                end
            end else begin
                hit_way_o <= '0;
            end
        end
    end

    assign hit_o = |hit_way_o;

`ifdef ITAG_PARITY_EN
    logic [N_WAY-1:0] perr_q;

    // Parity error flags, aligned with rvalid_o
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perr_q <= '0;
        end else if (rd_go) begin
            perr_q <= req_i & rd_perr;
        end else begin
            perr_q <= '0;
        end
    end

    assign parity_err_o = perr_q;
`else
    assign parity_err_o = '0;
`endif

endmodule

// File: tb/tb_sargantana_itag_memory_param.sv
// Directed testbench for sargantana_itag_memory_param (default parameters).
module tb_sargantana_itag_memory_param;

    localparam int N_WAY = 4;
    localparam int DEPTH = 64;
    localparam int TAG_W = 20;
    localparam int IDX_W = 6;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N_WAY-1:0]       req_i;
    logic                   we_i;
    logic                   vbit_i;
    logic                   flush_i;
    logic [TAG_W-1:0]       data_i;
    logic [IDX_W-1:0]       addr_i;
    logic [TAG_W-1:0]       cmp_tag_i;
    logic                   ready_o;
    logic                   rvalid_o;
    logic [N_WAY*TAG_W-1:0] tag_way_o;
    logic [N_WAY-1:0]       vbit_o;
    logic [N_WAY-1:0]       hit_way_o;
    logic                   hit_o;
    logic [N_WAY-1:0]       parity_err_o;

    int n_vec = 0;
    int n_err = 0;

    sargantana_itag_memory_param #(
        .N_WAY(N_WAY), .DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .vbit_i(vbit_i), .flush_i(flush_i), .data_i(data_i), .addr_i(addr_i),
        .cmp_tag_i(cmp_tag_i), .ready_o(ready_o), .rvalid_o(rvalid_o),
        .tag_way_o(tag_way_o), .vbit_o(vbit_o), .hit_way_o(hit_way_o),
        .hit_o(hit_o), .parity_err_o(parity_err_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] way_tag(input int w);
        return 32'(tag_way_o[w*TAG_W +: TAG_W]);
    endfunction

    task automatic drive(input logic [N_WAY-1:0] req, input logic we, input logic vb,
                         input logic fl, input logic [TAG_W-1:0] data,
                         input logic [IDX_W-1:0] addr, input logic [TAG_W-1:0] cmp);
        req_i = req; we_i = we; vbit_i = vb; flush_i = fl;
        data_i = data; addr_i = addr; cmp_tag_i = cmp;
    endtask

    // One active edge, then settle before sampling
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"},  32'(ready_o),      32'h0);
        check({tag, "_rvalid"}, 32'(rvalid_o),     32'h0);
        check({tag, "_tags"},   32'(|tag_way_o),   32'h0);
        check({tag, "_vbit"},   32'(vbit_o),       32'h0);
        check({tag, "_hit"},    32'(hit_way_o),    32'h0);
        check({tag, "_perr"},   32'(parity_err_o), 32'h0);
    endtask

    // Counts edges after release; requests stay on every cycle
    task automatic sweep_check(input string tag);
        for (int e = 1; e <= DEPTH; e++) begin
            step();
            check({tag, "_ready"}, 32'(ready_o), 32'(e == DEPTH));
            check({tag, "_rvalid"}, 32'(rvalid_o), 32'h0);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        drive(4'hF, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        step();
        check_zero_outputs("reset");
        rst_i = 1'b0;

        // Init sweep with requests on every cycle
        sweep_check("sweep");
        // Read of set 0 queued during the final sweep cycle comes back now
        step();
        check("init_rd_rvalid", 32'(rvalid_o), 32'h1);
        check("init_rd_vbit", 32'(vbit_o), 32'h0);
        check("init_rd_tags", 32'(|tag_way_o), 32'h0);
        check("init_rd_hit", 32'(hit_o), 32'h0);

        // Write 0xABCDE into set 5 way 2
        drive(4'b0100, 1'b1, 1'b1, 1'b0, 20'hABCDE, 6'd5, '0);
        step();
        check("wr_rvalid", 32'(rvalid_o), 32'h0);
        check("wr_hit", 32'(hit_way_o), 32'h0);

        // Read set 5, matching tag
        drive(4'b1111, 1'b0, 1'b0, 1'b0, '0, 6'd5, 20'hABCDE);
        step();
        check("rd5_rvalid", 32'(rvalid_o), 32'h1);
        check("rd5_vbit", 32'(vbit_o), 32'h4);
        check("rd5_hitway", 32'(hit_way_o), 32'h4);
        check("rd5_hit", 32'(hit_o), 32'h1);
        check("rd5_tag2", way_tag(2), 32'hABCDE);
        check("rd5_tag0", way_tag(0), 32'h0);

        // Same read, tag off by one
        drive(4'b1111, 1'b0, 1'b0, 1'b0, '0, 6'd5, 20'hABCDF);
        step();
        check("miss_hit", 32'(hit_o), 32'h0);
        check("miss_vbit", 32'(vbit_o), 32'h4);
        check("miss_tag2", way_tag(2), 32'hABCDE);

        // Idle: hit clears, tag/vbit hold
        drive(4'b0000, 1'b0, 1'b0, 1'b0, '0, 6'd5, 20'hABCDE);
        step();
        check("idle_rvalid", 32'(rvalid_o), 32'h0);
        check("idle_vbit", 32'(vbit_o), 32'h4);
        check("idle_tag2", way_tag(2), 32'hABCDE);

        // req_i=0 with we_i=1 is a no-op (set 5 way 2 must stay intact)
        drive(4'b0000, 1'b1, 1'b0, 1'b0, 20'h55555, 6'd5, '0);
        step();
        check("nop_rvalid", 32'(rvalid_o), 32'h0);

        // Partial read of way 0 only: way 2 output holds, vbit only for requested
        drive(4'b0001, 1'b0, 1'b0, 1'b0, '0, 6'd5, 20'hABCDE);
        step();
        check("part_rvalid", 32'(rvalid_o), 32'h1);
        check("part_vbit", 32'(vbit_o), 32'h0);
        check("part_tag2", way_tag(2), 32'hABCDE);
        check("part_hit", 32'(hit_o), 32'h0);

        // Multi-hot hit: ways 0 and 1 of set 7 hold the same tag
        drive(4'b0011, 1'b1, 1'b1, 1'b0, 20'h11111, 6'd7, '0);
        step();
        drive(4'b1111, 1'b0, 1'b0, 1'b0, '0, 6'd7, 20'h11111);
        step();
        check("multi_hitway", 32'(hit_way_o), 32'h3);
        check("multi_hit", 32'(hit_o), 32'h1);

        // Flush with concurrent write of 0x12345 to set 9 way 0
        drive(4'b0001, 1'b1, 1'b1, 1'b1, 20'h12345, 6'd9, '0);
        step();
        check("flush_vbit", 32'(vbit_o), 32'h0);
        check("flush_hit", 32'(hit_way_o), 32'h0);
        check("flush_rvalid", 32'(rvalid_o), 32'h0);
        drive(4'b1111, 1'b0, 1'b0, 1'b0, '0, 6'd9, 20'h12345);
        step();
        check("flrd9_rvalid", 32'(rvalid_o), 32'h1);
        check("flrd9_vbit", 32'(vbit_o), 32'h0);
        check("flrd9_tag0", way_tag(0), 32'h0);
        check("flrd9_hit", 32'(hit_o), 32'h0);
        // Tags survive the flush, valid bits do not
        drive(4'b1111, 1'b0, 1'b0, 1'b0, '0, 6'd5, 20'hABCDE);
        step();
        check("flrd5_tag2", way_tag(2), 32'hABCDE);
        check("flrd5_vbit", 32'(vbit_o), 32'h0);

        // Write then immediate read on the next cycle
        drive(4'b1000, 1'b1, 1'b1, 1'b0, 20'h0F0F0, 6'd9, '0);
        step();
        drive(4'b1000, 1'b0, 1'b0, 1'b0, '0, 6'd9, 20'h0F0F0);
        step();
        check("wrrd_hitway", 32'(hit_way_o), 32'h8);
        check("wrrd_tag3", way_tag(3), 32'h0F0F0);

`ifdef ITAG_PARITY_EN
        // Corrupt one stored tag bit of set 3 way 1, then read it
        drive(4'b0010, 1'b1, 1'b1, 1'b0, 20'h00123, 6'd3, '0);
        step();
        dut.mem[1][3][0] = ~dut.mem[1][3][0];
        drive(4'b1111, 1'b0, 1'b0, 1'b0, '0, 6'd3, 20'h00123);
        step();
        check("par_err", 32'(parity_err_o), 32'h2);
        check("par_hitway", 32'(hit_way_o), 32'h0);
        check("par_vbit", 32'(vbit_o), 32'h0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, '0, 6'd3, '0);
        step();
        check("par_clr", 32'(parity_err_o), 32'h0);
`endif

        // Async reset from READY with non-zero outputs (way 3 tag held)
        drive(4'b1111, 1'b0, 1'b0, 1'b0, '0, 6'd0, '0);
        rst_i = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        step();
        rst_i = 1'b0;

        // Let the sweep reach row 30, then reset for two cycles
        for (int e = 1; e <= 30; e++) begin
            step();
        end
        check("mid_ready", 32'(ready_o), 32'h0);
        rst_i = 1'b1;
        #1;
        check_zero_outputs("mid_rst");
        step();
        step();
        rst_i = 1'b0;
        sweep_check("resweep");
        // Set 9 way 3 was zeroed by the new sweep, valid cleared by reset
        drive(4'b1111, 1'b0, 1'b0, 1'b0, '0, 6'd9, 20'h0F0F0);
        step();
        step();
        check("resweep_tag3", way_tag(3), 32'h0);
        check("resweep_vbit", 32'(vbit_o), 32'h0);
        check("resweep_hit", 32'(hit_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sargantana_itag_memory_param.md
Name: sargantana_itag_memory_param

Overview:
Parametrised successor of the 4-way I-cache tag store, generic in way count, set depth and tag width. Holds per-way tags in a single-port behavioural array, per-way valid bits in flops, and compares tags in the read stage. Runs a hardware init sweep that zeroes the tag array after reset. Sits between the I-cache controller and the data array; provides a registered hit vector one cycle after a lookup.

Parameters:
N_WAY, 4, number of ways (1..8)
DEPTH, 64, sets per way; must be a power of two (elaboration-time assertion)
TAG_W, 20, tag width in bits
IDX_W, $clog2(DEPTH), derived localparam, set-index width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
req_i  in  N_WAY  per-way request/enable
we_i  in  1  1 = write requested ways, 0 = read
vbit_i  in  1  valid bit written with a tag
flush_i  in  1  invalidate all ways/sets
data_i  in  TAG_W  tag to write
addr_i  in  IDX_W  set index
cmp_tag_i  in  TAG_W  lookup tag, sampled with a read
ready_o  out  1  init sweep done, requests accepted
rvalid_o  out  1  one-cycle pulse, read results valid
tag_way_o  out  N_WAY x TAG_W  stored tag per way
vbit_o  out  N_WAY  valid bit per way
hit_way_o  out  N_WAY  per-way hit
hit_o  out  1  OR of hit_way_o
parity_err_o  out  N_WAY  per-way tag parity error (see Optional Feature)

Behaviour:
- Reset (async, rst_i=1): all valid bits 0; ready_o, rvalid_o, vbit_o, hit_way_o, hit_o, parity_err_o, tag_way_o = 0; FSM -> INIT; sweep counter = 0.
- FSM states: INIT, READY.
- INIT: each cycle writes all-zero tag (and parity) to row cnt in every way; cnt++. The write of row DEPTH-1 moves the FSM to READY. Rows 0..DEPTH-1 are written on edges 1..DEPTH after rst_i falls. ready_o = 1 from edge DEPTH onward.
- During INIT, req_i, we_i and flush_i are ignored and rvalid_o stays 0. Reset asserted mid-sweep restarts the sweep at row 0.
- READY read (|req_i, !we_i, !flush_i): latency 1.
  - Next cycle: rvalid_o = 1 for exactly one cycle.
  - For requested ways: tag_way_o[w] = stored tag; vbit_o[w] = valid bit.
  - For non-requested ways: vbit_o[w] = 0; tag_way_o[w] holds its previous value.
  - hit_way_o[w] = vbit_o[w] & (tag_way_o[w] == registered cmp_tag_i); hit_o = |hit_way_o.
  - Multi-hot hit_way_o is passed through unprioritised.
- READY write (|req_i, we_i, !flush_i): writes data_i and vbit_i into the requested ways only, at addr_i. rvalid_o = 0. Read outputs hold, except hit_way_o and hit_o, which go to 0.
- Read in cycle N+1 of a row written in cycle N returns the new tag and valid bit (no bypass needed, sequential port).
- Idle cycle (req_i = 0): rvalid_o = 0; hit_way_o and hit_o = 0; tag_way_o and vbit_o hold.
- flush_i (READY): all valid bits cleared in one cycle. Next cycle: vbit_o, hit_way_o and hit_o = 0; rvalid_o = 0.
  - Flush has priority; a concurrent req_i (read or write) is dropped, and its tag/valid write does not occur.
  - Tag contents are not cleared by flush.
- req_i = 0 with we_i = 1: no operation.

Optional Feature:
Macro ITAG_PARITY_EN.
- Defined: each way stores an even-parity bit over its tag (TAG_W+1 bits per way). A read recomputes parity. On mismatch:
  - parity_err_o[w] = 1, aligned with rvalid_o;
  - vbit_o[w] and hit_way_o[w] are forced to 0, so the access is treated as a miss.
  - The init sweep writes parity 0 alongside zero tags.
- Undefined: no parity storage; parity_err_o tied to 0.

Test Plan:
- Reset release, then requests every cycle -> ready_o low for 63 edges and high at edge 64; no rvalid_o before ready; every way reads tag 0x00000 with vbit 0.
- Write tag 0xABCDE, vbit 1, set 5, req_i = 4'b0100; next-cycle read set 5 with req_i = 4'b1111, cmp_tag_i = 0xABCDE -> rvalid_o = 1, vbit_o = 4'b0100, hit_way_o = 4'b0100, hit_o = 1.
- Same read with cmp_tag_i = 0xABCDF -> hit_o = 0, vbit_o = 4'b0100, tag_way_o[2] = 0xABCDE.
- flush_i together with a write of 0x12345 to set 9 way 0, then read set 9 -> vbit_o = 0, tag_way_o[0] = 0x00000 (write dropped), hit_o = 0.
- rst_i asserted at sweep row 30 for 2 cycles -> outputs zero asynchronously; ready_o rises 64 edges after the second release.
- ITAG_PARITY_EN: force a single-bit flip in the stored tag of set 3 way 1, then read with the matching cmp_tag_i -> parity_err_o = 4'b0010, hit_way_o[1] = 0, vbit_o[1] = 0.
